// File: rtl/fb_frame_sched.sv
// Per-frame draw scheduler: on each vblank rise, one background blit then one pass per
// enabled sprite into the back buffer; buffers swap only on a vblank that finds the frame complete.
module fb_frame_sched #(
    parameter int NUM_SPRITES = 16,
    parameter int FB_WORDS    = 76800,
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vblank,
    input  logic [NUM_SPRITES-1:0] sprt_mask,
    input  logic                   err_clr,
    output logic                   bkg_go,
    input  logic                   bkg_done,
    output logic                   sprt_go,
    output logic [IDX_W-1:0]       sprt_idx,
    input  logic                   sprt_done,
    output logic [ADDR_W-1:0]      fb_base,
    output logic                   front_sel,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   timeout_err
);
    typedef enum logic [2:0] {
        IDLE,
        BKG_GO,
        BKG_WAIT,
        SPR_SCAN,
        SPR_WAIT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_WORDS);

    state_t                 state_reg, state_next;
    logic                   vblank_q_reg;
    logic                   vb_rise;
    logic [NUM_SPRITES-1:0] mask_reg;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [CNT_W-1:0]       wait_cnt_reg, wait_cnt_next;
    logic                   bkg_go_reg;
    logic                   sprt_go_reg, sprt_go_next;
    logic                   frame_done_reg;
    logic                   busy_reg;
    logic                   front_sel_reg;
    logic [ADDR_W-1:0]      fb_base_reg;
    logic                   overrun_reg, timeout_err_reg;
    logic                   latch_mask, swap, wait_expired, timeout_hit, in_pass;

    assign vb_rise = vblank & ~vblank_q_reg;
    assign in_pass = (state_reg == BKG_GO) || (state_reg == BKG_WAIT) ||
                     (state_reg == SPR_SCAN) || (state_reg == SPR_WAIT);

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wait_cnt_next = wait_cnt_reg;
        sprt_go_next  = 1'b0;
        latch_mask    = 1'b0;
        swap          = 1'b0;
        timeout_hit   = 1'b0;
        wait_expired  = (wait_cnt_reg == CNT_LAST);
        case (state_reg)
            IDLE: begin
                if (vb_rise) begin
                    latch_mask = 1'b1;
                    state_next = BKG_GO;
                end
            end
            BKG_GO: begin
                wait_cnt_next = '0;
                state_next    = BKG_WAIT;
            end
            BKG_WAIT: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                // An expired wait stands in for the missing done pulse
                if (bkg_done || wait_expired) begin
                    timeout_hit = ~bkg_done;
                    idx_next    = '0;
                    state_next  = SPR_SCAN;
                end
            end
            SPR_SCAN: begin
                if (mask_reg[idx_reg]) begin
                    sprt_go_next  = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = SPR_WAIT;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            SPR_WAIT: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                if (sprt_done || wait_expired) begin
                    timeout_hit = ~sprt_done;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = SPR_SCAN;
                    end
                end
            end
            DONE: begin
                if (vb_rise) begin
                    swap       = 1'b1;
                    latch_mask = 1'b1;
                    state_next = BKG_GO;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            vblank_q_reg    <= 1'b0;
            mask_reg        <= '0;
            idx_reg         <= '0;
            wait_cnt_reg    <= '0;
            bkg_go_reg      <= 1'b0;
            sprt_go_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            front_sel_reg   <= 1'b0;
            fb_base_reg     <= BUF1_BASE;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vblank_q_reg   <= vblank;
            idx_reg        <= idx_next;
            wait_cnt_reg   <= wait_cnt_next;
            if (latch_mask) begin
                mask_reg <= sprt_mask;
            end
            bkg_go_reg     <= (state_next == BKG_GO);
            sprt_go_reg    <= sprt_go_next;
            frame_done_reg <= (state_next == DONE) && (state_reg != DONE);
            busy_reg       <= !((state_next == IDLE) || (state_next == DONE));
            if (swap) begin
                front_sel_reg <= ~front_sel_reg;
            end
            // Back buffer is whichever one the display is not scanning
            fb_base_reg    <= front_sel_reg ? '0 : BUF1_BASE;
            if (vb_rise && in_pass) begin
                overrun_reg <= 1'b1;
            end else if (err_clr) begin
                overrun_reg <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign bkg_go      = bkg_go_reg;
    assign sprt_go     = sprt_go_reg;
    assign sprt_idx    = idx_reg;
    assign frame_done  = frame_done_reg;
    assign busy        = busy_reg;
    assign front_sel   = front_sel_reg;
    assign fb_base     = fb_base_reg;
    assign overrun     = overrun_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_fb_frame_sched.sv
// Scoreboard bench for fb_frame_sched: stimulus queues expected go/done pulses with their
// cycle numbers; a negedge monitor pops and compares whenever the DUT pulses.
module tb_fb_frame_sched;
    localparam int FBW = 76800;
    localparam int TMO = 20;
    localparam int KB  = 0;
    localparam int KS  = 1;
    localparam int KF  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic [15:0] sprt_mask = '0;
    logic        err_clr = 1'b0;
    logic        bkg_done = 1'b0;
    logic        sprt_done = 1'b0;
    logic        bkg_go, sprt_go, front_sel, busy, frame_done, overrun, timeout_err;
    logic [3:0]  sprt_idx;
    logic [17:0] fb_base;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int kind;
        int idx;
        int at;
    } ev_t;
    ev_t exp_q[$];

    fb_frame_sched #(
        .NUM_SPRITES(16),
        .FB_WORDS(FBW),
        .ADDR_W(18),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vblank(vblank),
        .sprt_mask(sprt_mask),
        .err_clr(err_clr),
        .bkg_go(bkg_go),
        .bkg_done(bkg_done),
        .sprt_go(sprt_go),
        .sprt_idx(sprt_idx),
        .sprt_done(sprt_done),
        .fb_base(fb_base),
        .front_sel(front_sel),
        .busy(busy),
        .frame_done(frame_done),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            KB:      return "bkg_go";
            KS:      return "sprt_go";
            default: return "frame_done";
        endcase
    endfunction

    function automatic void push(input int k, input int i, input int at);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    task automatic mon_one(input int kind, input int idx);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got %s idx=%0d at cycle %0d, required no pulse",
                     kname(kind), idx, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc || (kind == KS && e.idx != idx)) begin
                errors++;
                $display("FAIL pulse_order: got %s idx=%0d at cycle %0d, required %s idx=%0d at cycle %0d",
                         kname(kind), idx, cyc, kname(e.kind), e.idx, e.at);
            end else begin
                $display("txn %s idx=%0d cycle=%0d ok", kname(kind), idx, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bkg_go)     mon_one(KB, 0);
        if (sprt_go)    mon_one(KS, int'(sprt_idx));
        if (frame_done) mon_one(KF, 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bkg_go"},      32'(bkg_go), 32'd0);
        chk({tag, "_sprt_go"},     32'(sprt_go), 32'd0);
        chk({tag, "_sprt_idx"},    32'(sprt_idx), 32'd0);
        chk({tag, "_frame_done"},  32'(frame_done), 32'd0);
        chk({tag, "_busy"},        32'(busy), 32'd0);
        chk({tag, "_front_sel"},   32'(front_sel), 32'd0);
        chk({tag, "_fb_base"},     32'(fb_base), 32'(FBW));
        chk({tag, "_overrun"},     32'(overrun), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // One frame starting with a vblank rise in the current cycle. bd: cycles from rise to
    // bkg_done (or to the timeout when tmo=1); sd: cycles from each sprt_go to its done;
    // ovr_off: offset of an extra mid-frame rise (0 = none); exp_front: front_sel after the rise.
    task automatic frame(input logic [15:0] mask, input int bd, input int sd,
                         input int ovr_off, input bit tmo, input bit exp_front, input string tag);
        int r, t, pos, go_c;
        int sdone[$];
        r = cyc;
        t = r + bd;
        push(KB, 0, r + 1);
        pos = t + 1;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                go_c = pos + 1;
                push(KS, i, go_c);
                sdone.push_back(go_c + sd);
                pos = go_c + sd + 1;
            end else begin
                pos = pos + 1;
            end
        end
        push(KF, 0, pos);
        sprt_mask = mask;
        while (cyc <= pos) begin
            if (cyc == r + 1) chk({tag, "_front_sel"}, 32'(front_sel), 32'(exp_front));
            if (cyc == r + 2) chk({tag, "_fb_base"}, 32'(fb_base), exp_front ? 32'd0 : 32'(FBW));
            if (tmo && cyc == t)     chk({tag, "_timeout_before"}, 32'(timeout_err), 32'd0);
            if (tmo && cyc == t + 1) chk({tag, "_timeout_after"}, 32'(timeout_err), 32'd1);
            if (cyc > r) sprt_mask = ~mask;
            vblank    = (cyc == r) || (ovr_off > 0 && cyc == r + ovr_off);
            bkg_done  = !tmo && (cyc == t);
            sprt_done = (sdone.size() > 0 && cyc == sdone[0]);
            if (sprt_done) void'(sdone.pop_front());
            tick();
        end
        vblank    = 1'b0;
        bkg_done  = 1'b0;
        sprt_done = 1'b0;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("reset");
        tick();

        // First frame out of IDLE: no swap
        frame(16'h0005, 10, 3, 0, 1'b0, 1'b0, "t1");
        chk("t1_front_end", 32'(front_sel), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        frame(16'h0005, 10, 3, 0, 1'b0, 1'b1, "t2");

        // Rise during SPR_WAIT idx0 (cycles r+12..r+15)
        frame(16'h0005, 10, 3, 13, 1'b0, 1'b0, "t3a");
        chk("t3_overrun_set", 32'(overrun), 32'd1);
        chk("t3_no_swap", 32'(front_sel), 32'd0);
        frame(16'h0003, 6, 2, 0, 1'b0, 1'b1, "t3b");
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_overrun_clr", 32'(overrun), 32'd0);

        // Empty mask, with a rise landing together with bkg_done
        frame(16'h0000, 5, 3, 5, 1'b0, 1'b0, "t4");
        chk("t4_overrun_with_done", 32'(overrun), 32'd1);
        chk("t4_no_timeout", 32'(timeout_err), 32'd0);

        // bkg_done withheld: wait cycle 19 (r+21) acts as the done
        frame(16'h0001, 21, 3, 0, 1'b1, 1'b1, "t5");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_overrun_clr", 32'(overrun), 32'd0);
        chk("t5_timeout_clr", 32'(timeout_err), 32'd0);

        // Last slot only: SPR_WAIT idx15 exits straight to DONE
        frame(16'h8000, 3, 2, 0, 1'b0, 1'b0, "t6a");

        // Reset while waiting on sprite 5
        r = cyc;
        sprt_mask = 16'h0020;
        push(KB, 0, r + 1);
        push(KS, 5, r + 10);
        while (cyc < r + 12) begin
            vblank   = (cyc == r);
            bkg_done = (cyc == r + 3);
            if (cyc > r) sprt_mask = 16'h0000;
            tick();
        end
        vblank   = 1'b0;
        bkg_done = 1'b0;
        chk("t6_idx_before_reset", 32'(sprt_idx), 32'd5);
        chk("t6_busy_before_reset", 32'(busy), 32'd1);
        chk("t6_front_before_reset", 32'(front_sel), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("t6");
        sprt_done = 1'b1;
        bkg_done  = 1'b1;
        tick();
        sprt_done = 1'b0;
        bkg_done  = 1'b0;
        repeat (3) tick();
        chk("t6_stray_busy", 32'(busy), 32'd0);
        chk("t6_stray_idx", 32'(sprt_idx), 32'd0);

        // Restart from IDLE after reset: no swap
        frame(16'h0000, 4, 3, 0, 1'b0, 1'b0, "t6b");

        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
